// File: rtl/ring_phase_monitor.sv
// Ring counter phase monitor: one-hot legality, rotation order and lock tracking,
// plus revolution counting and sticky error capture.
module ring_phase_monitor #(
   parameter int WIDTH      = 4,
   parameter int REV_W      = 8,
   parameter int LOCK_CNT   = 2,
   parameter int SHIFT_LEFT = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         ring_in,
   input  logic                     clear,
   output logic [$clog2(WIDTH)-1:0] phase_idx,
   output logic                     phase_valid,
   output logic                     locked,
   output logic [REV_W-1:0]         rev_count,
   output logic                     rev_pulse,
   output logic                     err_onehot,
   output logic                     err_seq,
   output logic                     err_sticky
);

   localparam int IW = $clog2(WIDTH);
   localparam int CW = $clog2(LOCK_CNT + 1);

   typedef enum logic [1:0] {
      S_SEARCH,
      S_TRACK,
      S_LOCKED,
      S_FAULT
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt_nxt;
   logic [CW-1:0]    w_cnt_inc;
   logic [WIDTH-1:0] r_prev;
   logic [WIDTH-1:0] w_rot;
   logic [IW-1:0]    w_idx;
   logic             w_onehot;
   logic             w_hold;
   logic             w_step;
   logic             w_skip;
   logic             w_wrap_bit;
   logic             w_err_seq;
   logic             w_rev;
   logic             w_set_sticky;

   logic [IW-1:0]    r_phase_idx;
   logic             r_phase_valid;
   logic [REV_W-1:0] r_rev_count;
   logic             r_rev_pulse;
   logic             r_err_onehot;
   logic             r_err_seq;
   logic             r_err_sticky;

   // Classify the incoming sample against the last legal one-hot sample.
   always_comb begin
      w_onehot   = $onehot(ring_in);
      w_rot      = (SHIFT_LEFT != 0) ? {r_prev[WIDTH-2:0], r_prev[WIDTH-1]}
                                     : {r_prev[0], r_prev[WIDTH-1:1]};
      w_hold     = w_onehot && (ring_in == r_prev);
      w_step     = w_onehot && (ring_in == w_rot);
      w_skip     = w_onehot && !w_hold && !w_step;
      w_wrap_bit = (SHIFT_LEFT != 0) ? ring_in[0] : ring_in[WIDTH-1];
      w_idx      = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (ring_in[i]) w_idx = i[IW-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_SEARCH;
         r_cnt   <= '0;
         r_prev  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_onehot) r_prev <= ring_in;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_cnt_inc   = r_cnt + 1'b1;
      unique case (r_state)
         S_SEARCH, S_FAULT: begin
            if (w_onehot) begin
               w_state_nxt = S_TRACK;
               w_cnt_nxt   = '0;
            end
         end
         S_TRACK: begin
            if (w_step) begin
               w_cnt_nxt = w_cnt_inc;
               if (w_cnt_inc == CW'(LOCK_CNT)) w_state_nxt = S_LOCKED;
            end else if (!w_hold) begin
               w_state_nxt = S_SEARCH;
            end
         end
         S_LOCKED: begin
            if (!w_step && !w_hold) w_state_nxt = S_FAULT;
         end
         default: w_state_nxt = S_SEARCH;
      endcase
   end

   // The step that completes locking is taken in TRACK, so it never counts.
   always_comb begin
      w_err_seq    = w_skip && (r_state == S_TRACK || r_state == S_LOCKED);
      w_rev        = (r_state == S_LOCKED) && w_step && w_wrap_bit;
      w_set_sticky = (r_state == S_LOCKED) && (!w_onehot || w_skip);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_phase_idx   <= '0;
         r_phase_valid <= 1'b0;
         r_rev_count   <= '0;
         r_rev_pulse   <= 1'b0;
         r_err_onehot  <= 1'b0;
         r_err_seq     <= 1'b0;
         r_err_sticky  <= 1'b0;
      end else begin
         r_phase_valid <= w_onehot;
         r_err_onehot  <= !w_onehot;
         r_err_seq     <= w_err_seq;
         r_rev_pulse   <= w_rev;
         if (w_onehot) r_phase_idx <= w_idx;
         if (clear) r_rev_count <= '0;
         else if (w_rev) r_rev_count <= r_rev_count + 1'b1;
         if (clear) r_err_sticky <= 1'b0;
         else if (w_set_sticky) r_err_sticky <= 1'b1;
      end
   end

   assign phase_idx   = r_phase_idx;
   assign phase_valid = r_phase_valid;
   assign locked      = (r_state == S_LOCKED);
   assign rev_count   = r_rev_count;
   assign rev_pulse   = r_rev_pulse;
   assign err_onehot  = r_err_onehot;
   assign err_seq     = r_err_seq;
   assign err_sticky  = r_err_sticky;

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Bench for ring_phase_monitor: directed scenarios and a randomized run, all
// checked against an index-based behavioural model of the phase monitor.
module tb_ring_phase_monitor;

   localparam int W  = 4;
   localparam int RW = 2;
   localparam int LC = 2;
   localparam int SL = 1;

   logic          clk;
   logic          rst;
   logic [W-1:0]  ring_in;
   logic          clear;
   logic [1:0]    phase_idx;
   logic          phase_valid;
   logic          locked;
   logic [RW-1:0] rev_count;
   logic          rev_pulse;
   logic          err_onehot;
   logic          err_seq;
   logic          err_sticky;

   ring_phase_monitor #(
      .WIDTH(W), .REV_W(RW), .LOCK_CNT(LC), .SHIFT_LEFT(SL)
   ) dut (
      .clk(clk), .rst(rst), .ring_in(ring_in), .clear(clear),
      .phase_idx(phase_idx), .phase_valid(phase_valid), .locked(locked),
      .rev_count(rev_count), .rev_pulse(rev_pulse), .err_onehot(err_onehot),
      .err_seq(err_seq), .err_sticky(err_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Model: 0 SEARCH, 1 TRACK, 2 LOCKED, 3 FAULT; phases as integer indices.
   int m_state, m_pidx, m_cnt, m_idx, m_rev;
   bit m_valid, m_eon, m_eseq, m_rp, m_sticky;

   logic [10:0] dut_vec;
   assign dut_vec = {phase_idx, phase_valid, locked, rev_count,
                     rev_pulse, err_onehot, err_seq, err_sticky};

   function automatic logic [10:0] exp_vec();
      return {2'(m_idx), m_valid, (m_state == 2), RW'(m_rev),
              m_rp, m_eon, m_eseq, m_sticky};
   endfunction

   task automatic model_reset();
      m_state = 0; m_pidx = -1; m_cnt = 0; m_idx = 0; m_rev = 0;
      m_valid = 0; m_eon = 0; m_eseq = 0; m_rp = 0; m_sticky = 0;
   endtask

   task automatic model_step(input logic [W-1:0] r, input logic c);
      bit oh, hold, step;
      int idx, nxt;
      oh  = ($countones(r) == 1);
      idx = 0;
      for (int i = 0; i < W; i++) if (r[i]) idx = i;
      nxt  = (SL != 0) ? (m_pidx + 1) % W : (m_pidx + W - 1) % W;
      hold = oh && (m_pidx >= 0) && (idx == m_pidx);
      step = oh && (m_pidx >= 0) && (idx == nxt);
      m_valid = oh; m_eon = !oh; m_eseq = 0; m_rp = 0;
      if (oh) m_idx = idx;
      case (m_state)
         0, 3: if (oh) begin m_state = 1; m_cnt = 0; end
         1: begin
            if (step) begin
               m_cnt++;
               if (m_cnt == LC) m_state = 2;
            end else if (!hold) begin
               m_state = 0;
               m_eseq = oh;
            end
         end
         default: begin
            if (step) begin
               if (idx == ((SL != 0) ? 0 : W - 1)) begin
                  m_rev = (m_rev + 1) % (1 << RW);
                  m_rp = 1;
               end
            end else if (!hold) begin
               m_state = 3; m_sticky = 1; m_eseq = oh;
            end
         end
      endcase
      if (oh) m_pidx = idx;
      if (c) begin m_rev = 0; m_sticky = 0; end
   endtask

   // Starts and ends on a falling edge; model advances with the rising edge.
   task automatic apply(input logic [W-1:0] r, input logic c);
      ring_in = r; clear = c;
      @(posedge clk); #1;
      model_step(r, c);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0; ring_in = 4'b0100; clear = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (dut_vec !== 11'b0) begin
            n_bad++;
            $display("FAIL reset_hold got %b want %b", dut_vec, 11'b0);
         end
      end
      @(negedge clk);
      rst = 1'b1;
      apply(4'b0001, 1'b0);
      n_cmp++;
      if ({phase_valid, phase_idx, locked} !== 4'b1000) begin
         n_bad++;
         $display("FAIL reset_first got %b want %b",
                  {phase_valid, phase_idx, locked}, 4'b1000);
      end
   endtask

   task automatic test_lock_count();
      logic [W-1:0] seq [14] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001,
                                  4'b0010, 4'b0100, 4'b1000, 4'b0001,
                                  4'b0010, 4'b0100, 4'b1000, 4'b0001,
                                  4'b0010, 4'b0100};
      for (int i = 0; i < 12; i++) begin
         apply(seq[i], 1'b0);
         n_cmp++;
         if (dut_vec !== exp_vec()) begin
            n_bad++;
            $display("FAIL lock_seq[%0d] got %b want %b", i, dut_vec, exp_vec());
         end
         if (i == 1) begin
            n_cmp++;
            if (locked !== 1'b1) begin
               n_bad++;
               $display("FAIL lock_after_0100 got %b want 1", locked);
            end
         end
         if (i == 3 || i == 7 || i == 11) begin
            n_cmp++;
            if (rev_pulse !== 1'b1) begin
               n_bad++;
               $display("FAIL rev_pulse[%0d] got %b want 1", i, rev_pulse);
            end
         end
      end
      n_cmp++;
      if (rev_count !== 2'd3) begin
         n_bad++;
         $display("FAIL rev_count_3 got %0d want 3", rev_count);
      end
   endtask

   task automatic test_illegal();
      apply(4'b0010, 1'b0);
      apply(4'b0100, 1'b0);
      apply(4'b0110, 1'b0);
      n_cmp++;
      if ({err_onehot, phase_valid, phase_idx, locked, err_sticky} !== 6'b101001) begin
         n_bad++;
         $display("FAIL illegal_flags got %b want %b",
                  {err_onehot, phase_valid, phase_idx, locked, err_sticky}, 6'b101001);
      end
      apply(4'b0001, 1'b0);
      n_cmp++;
      if (err_onehot !== 1'b0) begin
         n_bad++;
         $display("FAIL illegal_pulse_len got %b want 0", err_onehot);
      end
      apply(4'b0010, 1'b0);
      apply(4'b0100, 1'b0);
      n_cmp++;
      if ({locked, err_sticky} !== 2'b11 || dut_vec !== exp_vec()) begin
         n_bad++;
         $display("FAIL illegal_relock got %b want %b", dut_vec, exp_vec());
      end
   endtask

   task automatic test_skip_hold();
      apply(4'b0100, 1'b1);
      n_cmp++;
      if ({locked, err_sticky, rev_count} !== 4'b1000) begin
         n_bad++;
         $display("FAIL hold_clear got %b want %b",
                  {locked, err_sticky, rev_count}, 4'b1000);
      end
      for (int i = 0; i < 2; i++) begin
         apply(4'b0100, 1'b0);
         n_cmp++;
         if ({err_onehot, err_seq, locked, rev_count} !== 5'b00100 ||
             dut_vec !== exp_vec()) begin
            n_bad++;
            $display("FAIL hold[%0d] got %b want %b", i, dut_vec, exp_vec());
         end
      end
      apply(4'b0001, 1'b0);
      n_cmp++;
      if ({err_seq, err_onehot, err_sticky, locked} !== 4'b1010) begin
         n_bad++;
         $display("FAIL skip got %b want %b",
                  {err_seq, err_onehot, err_sticky, locked}, 4'b1010);
      end
   endtask

   task automatic test_clear_wrap();
      apply(4'b0010, 1'b0);
      apply(4'b0100, 1'b0);
      apply(4'b1000, 1'b0);
      n_cmp++;
      if (locked !== 1'b1) begin
         n_bad++;
         $display("FAIL wrap_lock got %b want 1", locked);
      end
      for (int rv = 1; rv <= 4; rv++) begin
         if (rv > 1) begin
            apply(4'b0010, 1'b0);
            apply(4'b0100, 1'b0);
            apply(4'b1000, 1'b0);
         end
         apply(4'b0001, 1'b0);
         n_cmp++;
         if ({rev_pulse, rev_count} !== {1'b1, 2'(rv % 4)}) begin
            n_bad++;
            $display("FAIL wrap_rev[%0d] got %b want %b", rv,
                     {rev_pulse, rev_count}, {1'b1, 2'(rv % 4)});
         end
      end
      apply(4'b0010, 1'b0);
      apply(4'b0100, 1'b0);
      apply(4'b1000, 1'b0);
      apply(4'b0001, 1'b1);
      n_cmp++;
      if ({rev_pulse, rev_count, err_sticky} !== 4'b1000) begin
         n_bad++;
         $display("FAIL clear_on_rev got %b want %b",
                  {rev_pulse, rev_count, err_sticky}, 4'b1000);
      end
      apply(4'b0011, 1'b1);
      n_cmp++;
      if ({err_onehot, err_sticky, locked} !== 3'b100) begin
         n_bad++;
         $display("FAIL clear_on_err got %b want %b",
                  {err_onehot, err_sticky, locked}, 3'b100);
      end
   endtask

   task automatic test_async_reset();
      logic [W-1:0] seq [10] = '{4'b0001, 4'b0010, 4'b0100, 4'b1100, 4'b0100,
                                  4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
      foreach (seq[i]) apply(seq[i], 1'b0);
      n_cmp++;
      if (rev_pulse !== 1'b0 || dut_vec !== exp_vec()) begin
         n_bad++;
         $display("FAIL pre_async got %b want %b", dut_vec, exp_vec());
      end
      apply(4'b0001, 1'b0);
      n_cmp++;
      if ({locked, rev_count, err_sticky} !== 4'b1011) begin
         n_bad++;
         $display("FAIL pre_async_state got %b want %b",
                  {locked, rev_count, err_sticky}, 4'b1011);
      end
      @(posedge clk); #3;
      rst = 1'b0;
      #1;
      n_cmp++;
      if (dut_vec !== 11'b0) begin
         n_bad++;
         $display("FAIL async_reset got %b want %b", dut_vec, 11'b0);
      end
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      apply(4'b0100, 1'b0);
      apply(4'b1000, 1'b0);
      apply(4'b0001, 1'b0);
      n_cmp++;
      if ({locked, rev_pulse} !== 2'b10 || dut_vec !== exp_vec()) begin
         n_bad++;
         $display("FAIL async_relock got %b want %b", dut_vec, exp_vec());
      end
   endtask

   task automatic test_random();
      logic [W-1:0] r;
      logic         c;
      int           p, base;
      for (int n = 0; n < 400; n++) begin
         p    = $urandom_range(0, 99);
         base = (m_pidx < 0) ? 0 : m_pidx;
         if (p < 10) begin
            r = W'($urandom_range(0, 15));
            if ($countones(r) == 1) r = ~r;
         end else if (p < 16) begin
            r = W'(1 << ((base + 2) % W));
         end else if (p < 36) begin
            r = W'(1 << base);
         end else begin
            r = W'(1 << ((base + 1) % W));
         end
         c = ($urandom_range(0, 24) == 0);
         apply(r, c);
         n_cmp++;
         if (dut_vec !== exp_vec()) begin
            n_bad++;
            $display("FAIL random[%0d] in=%b clr=%b got %b want %b",
                     n, r, c, dut_vec, exp_vec());
         end
      end
   endtask

   initial begin
      test_reset();
      test_lock_count();
      test_illegal();
      test_skip_hold();
      test_clear_wrap();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
